// File: rtl/line_writeback.sv
// Streams one cache line out of a registered-read RAM through a 2-entry output FIFO.
// Reads are issued on a credit basis so that data in flight can always be buffered.
module line_writeback #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int LINE_WORDS = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-OFF_W-1:0] lineIndex,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH-1:0]       ramReadAddress,
  input  logic [WIDTH-1:0]            ramReadData,
  output logic [WIDTH-1:0]            outData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        outLast
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  state_t                      r_state, w_next;
  logic [ADDR_WIDTH-OFF_W-1:0] r_line;
  logic [OFF_W-1:0]            r_offset;
  logic                        r_inflight;
  logic                        r_inflight_last;
  logic [1:0][WIDTH-1:0]       r_fifo_data;
  logic [1:0]                  r_fifo_last;
  logic                        r_wptr, r_rptr;
  logic [1:0]                  r_count;
  logic                        r_done;

  logic       w_valid, w_pop, w_push, w_issue, w_last_issue, w_final_pop;
  logic [2:0] w_pending;

  assign w_valid   = (r_count != 2'd0);
  assign w_pop     = w_valid && outReady;
  assign w_push    = r_inflight;
  // Words that will be held after this edge, excluding any read issued now.
  assign w_pending = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == ISSUE) && (w_pending < 3'd2);
  assign w_last_issue = w_issue && (r_offset == LAST_OFF);
  assign w_final_pop  = w_pop && r_fifo_last[r_rptr];

  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign ramReadAddress = {r_line, r_offset};
  assign outValid       = w_valid;
  assign outData        = r_fifo_data[r_rptr];
  assign outLast        = w_valid && r_fifo_last[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)        w_next = ISSUE;
      ISSUE:   if (w_last_issue) w_next = DRAIN;
      DRAIN:   if (w_final_pop)  w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
  end

  // Offset holds at the last word instead of wrapping into the next line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line          <= '0;
      r_offset        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_last     <= '0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= '0;
      r_done          <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_line   <= lineIndex;
        r_offset <= '0;
      end else if (w_issue && !w_last_issue) begin
        r_offset <= r_offset + OFF_W'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      if (w_push) begin
        r_fifo_last[r_wptr] <= r_inflight_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
      r_done  <= (r_state == DRAIN) && w_final_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_data[r_wptr] <= ramReadData;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(w_push && !w_pop && r_count == 2'd2));
  end

endmodule
